// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - APB bus bundle between the request arbiter and one completer
// Ports (modports):
//   master : drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot, samples prdata/pready/pslverr
//   slave  : the completer side, mirror image of master
interface apb_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter funnelling NUM_REQ requesters onto one APB master
// Ports:
//   pclk, reset                 : clock, synchronous active-high reset
//   req_valid/req_write         : per-requester request and direction (1 = write)
//   req_addr/req_wdata/req_pprot: packed per-requester transfer fields
//   grant                       : one-hot owner of the transfer in flight (zero in IDLE)
//   done                        : one-hot single-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout: response status, valid while done is nonzero
//   apb                         : APB master side of the bus bundle
module apb_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]       req_pprot,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    apb_req_arbiter_if.master          apb
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [SW-1:0]           pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [IW-1:0]           ptr_q, ptr_d;

    // Round-robin search: first valid requester at or after ptr_q, wrapping.
    logic                    found;
    logic [IW-1:0]           win_idx;
    logic [IW:0]             cand_sum;
    logic [IW-1:0]           cand;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IW+1)'(NUM_REQ);
            end
            cand = cand_sum[IW-1:0];
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        grant_d       = grant_q;
        wcnt_d        = wcnt_q;
        ptr_d         = ptr_q;
        // Response outputs are single-cycle: zero unless this cycle completes.
        done_d        = '0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write[win_idx];
                    paddr_d   = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d  = req_write[win_idx] ?
                                req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
                    pstrb_d   = req_write[win_idx] ? '1 : '0;
                    pprot_d   = req_pprot[int'(win_idx)*3 +: 3];
                    grant_d   = NUM_REQ'(1) << win_idx;
                    ptr_d     = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                    wcnt_d    = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (apb.pready || (wcnt_q + CW'(1) == CW'(TIMEOUT))) begin
                    state_d   = IDLE;
                    done_d    = grant_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    pstrb_d   = '0;
                    pprot_d   = '0;
                    grant_d   = '0;
                    if (apb.pready) begin
                        rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                        rsp_err_d   = apb.pslverr;
                    end else begin
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wcnt_q        <= '0;
            ptr_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wcnt_q        <= wcnt_d;
            ptr_q         <= ptr_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
    assign apb.pprot   = pprot_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with a configurable APB completer
module tb_apb_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 16;

    logic             pclk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid, req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*3-1:0]  req_pprot;
    logic [NR-1:0]    grant, done;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err, rsp_timeout;

    apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .pclk(pclk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pprot(req_pprot),
        .grant(grant), .done(done), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .apb(bus)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [NR-1:0] grant;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [3:0]    pstrb;
        logic [2:0]    pprot;
        int            pcyc;
        int            gap;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Completer configuration
    int            cfg_wait = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_err = 1'b0;

    initial begin
        int acc;
        acc = 0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.psel && bus.penable) begin
                if (acc == cfg_wait) begin
                    bus.pready  = 1'b1;
                    bus.prdata  = cfg_rdata;
                    bus.pslverr = cfg_err;
                end else begin
                    bus.pready  = 1'b0;
                    bus.prdata  = 32'h0BAD_0BAD;
                    bus.pslverr = 1'($urandom_range(0, 1));
                end
                acc++;
            end else begin
                // Noise outside ACCESS must be ignored by the arbiter.
                bus.pready  = 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom;
                acc = 0;
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard at SETUP and at done.
    logic        mon_en = 1'b0;
    logic        prev_psel = 1'b0;
    logic [76:0] prev_v = '0;
    int          cyc = 0;
    int          last_done = 0;
    int          psel_run = 0;

    initial begin
        logic [76:0] cur_v;
        exp_t e;
        forever begin
            @(negedge pclk);
            if (mon_en) begin
                cyc++;
                cur_v = {bus.psel, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, grant};
                chk("penable_without_psel", bus.penable & ~bus.psel, 1'b0);
                if (prev_psel && bus.psel) chk("hold_while_selected", cur_v, prev_v);
                if (!bus.psel) chk("grant_idle_zero", grant, 0);
                if (bus.psel) psel_run++;
                if (bus.psel && !bus.penable) begin
                    chk("setup_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb[0];
                        chk("setup_grant", grant, e.grant);
                        chk("setup_pwrite", bus.pwrite, e.pwrite);
                        chk("setup_paddr", bus.paddr, e.paddr);
                        chk("setup_pwdata", bus.pwdata, e.pwdata);
                        chk("setup_pstrb", bus.pstrb, e.pstrb);
                        chk("setup_pprot", bus.pprot, e.pprot);
                    end
                end
                if (done != 0) begin
                    chk("done_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("done_onehot", done, e.grant);
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_timeout", rsp_timeout, e.tmo);
                        chk("psel_cycles", psel_run, e.pcyc);
                        chk("psel_low_at_done", {bus.psel, bus.penable}, 2'b00);
                        if (e.gap != 0) chk("done_gap", cyc - last_done, e.gap);
                    end
                    last_done = cyc;
                end
                if (!bus.psel) psel_run = 0;
                prev_psel = bus.psel;
                prev_v    = cur_v;
            end
        end
    end

    task automatic issue(input int idx, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [2:0] pr);
        req_write[idx]           = wr;
        req_addr[idx*AW +: AW]   = a;
        req_wdata[idx*DW +: DW]  = wd;
        req_pprot[idx*3 +: 3]    = pr;
        req_valid[idx]           = 1'b1;
    endtask

    task automatic push_exp(input int idx, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [2:0] pr, input logic [DW-1:0] rd,
                            input logic err, input logic tmo, input int pcyc, input int gap);
        exp_t e;
        e.grant  = NR'(1) << idx;
        e.pwrite = wr;
        e.paddr  = a;
        e.pwdata = wr ? wd : '0;
        e.pstrb  = wr ? 4'hF : 4'h0;
        e.pprot  = pr;
        e.pcyc   = pcyc;
        e.gap    = gap;
        e.rdata  = (wr || tmo) ? '0 : rd;
        e.err    = err;
        e.tmo    = tmo;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int idx, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge pclk);
            if (done[idx]) break;
        end
        chk("done_within_budget", done[idx], 1'b1);
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        int cnt;
        int acc;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_pprot = '0;
        repeat (3) @(negedge pclk);
        chk("reset_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot}, 0);
        chk("reset_grant_done", {grant, done}, 0);
        chk("reset_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Round-robin with all four requesting and a zero-wait completer
        cfg_wait = 0; cfg_rdata = 32'hA5A5_0001; cfg_err = 1'b0;
        for (int i = 0; i < NR; i++) issue(i, 1'b0, 32'h100 + 32'(i*4), 32'hFFFF_0000 + 32'(i), 3'(i));
        push_exp(0, 1'b0, 32'h100, 0, 3'd0, cfg_rdata, 1'b0, 1'b0, 2, 0);
        push_exp(1, 1'b0, 32'h104, 0, 3'd1, cfg_rdata, 1'b0, 1'b0, 2, 3);
        push_exp(2, 1'b0, 32'h108, 0, 3'd2, cfg_rdata, 1'b0, 1'b0, 2, 3);
        push_exp(3, 1'b0, 32'h10C, 0, 3'd3, cfg_rdata, 1'b0, 1'b0, 2, 3);
        push_exp(0, 1'b0, 32'h100, 0, 3'd0, cfg_rdata, 1'b0, 1'b0, 2, 3);
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 5; n++) begin
            @(negedge pclk);
            if (done != 0) cnt++;
        end
        req_valid = '0;
        chk("rr_done_count", cnt, 5);
        repeat (3) @(negedge pclk);

        // Single read with two wait cycles; wdata is garbage that must not reach pwdata
        cfg_wait = 2; cfg_rdata = 32'hDEAD_BEEF; cfg_err = 1'b0;
        issue(0, 1'b0, 32'h4, 32'hCAFE_F00D, 3'b111);
        push_exp(0, 1'b0, 32'h4, 32'hCAFE_F00D, 3'b111, cfg_rdata, 1'b0, 1'b0, 4, 0);
        wait_done(0, 50);
        repeat (2) @(negedge pclk);

        // Unaligned write from requester 2, completer flags an error; read data must be masked
        cfg_wait = 1; cfg_rdata = 32'hFFFF_0000; cfg_err = 1'b1;
        issue(2, 1'b1, 32'h3, 32'h1234_5678, 3'b010);
        push_exp(2, 1'b1, 32'h3, 32'h1234_5678, 3'b010, cfg_rdata, 1'b1, 1'b0, 3, 0);
        wait_done(2, 50);
        repeat (2) @(negedge pclk);

        // Completer never ready: timeout after TO wait cycles
        cfg_wait = 1000; cfg_rdata = 32'h7777_7777; cfg_err = 1'b0;
        issue(1, 1'b0, 32'h40, 32'h0, 3'b000);
        push_exp(1, 1'b0, 32'h40, 32'h0, 3'b000, cfg_rdata, 1'b1, 1'b1, TO + 1, 0);
        wait_done(1, 60);
        repeat (2) @(negedge pclk);

        // Reset during the third ACCESS wait cycle aborts without done
        cfg_wait = 10; cfg_err = 1'b0;
        issue(1, 1'b0, 32'h80, 32'h0, 3'b001);
        push_exp(1, 1'b0, 32'h80, 32'h0, 3'b001, cfg_rdata, 1'b0, 1'b0, 0, 0);
        acc = 0;
        for (int n = 0; n < 40 && acc < 3; n++) begin
            @(negedge pclk);
            if (bus.psel && bus.penable) acc++;
        end
        chk("abort_reached_wait3", acc, 3);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge pclk);
        chk("abort_outputs_zero", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
            bus.pstrb, bus.pprot, grant, done, rsp_rdata, rsp_err, rsp_timeout}, 0);
        sb.delete();
        reset = 1'b0;
        repeat (5) @(negedge pclk);

        // After reset the pointer restarts at 0, even though requester 2 is also waiting
        cfg_wait = 0; cfg_rdata = 32'h0000_5A5A; cfg_err = 1'b0;
        issue(0, 1'b0, 32'h200, 32'h0, 3'b100);
        issue(2, 1'b1, 32'h208, 32'hABCD_0123, 3'b001);
        push_exp(0, 1'b0, 32'h200, 32'h0, 3'b100, cfg_rdata, 1'b0, 1'b0, 2, 0);
        push_exp(2, 1'b1, 32'h208, 32'hABCD_0123, 3'b001, cfg_rdata, 1'b0, 1'b0, 2, 3);
        wait_done(0, 50);
        wait_done(2, 50);
        repeat (4) @(negedge pclk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 The block SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase wait cycles.
REQ-005 The block SHALL have the following ports: pclk, input, 1, clock.
REQ-006 reset, input, 1: reset, synchronous, active-high.
REQ-007 req_valid, input, NUM_REQ: per-requester transfer request.
REQ-008 req_write, input, NUM_REQ: per-requester direction, 1 = write.
REQ-009 req_addr, input, NUM_REQ*ADDR_WIDTH: packed per-requester address.
REQ-010 req_wdata, input, NUM_REQ*DATA_WIDTH: packed per-requester write data.
REQ-011 req_pprot, input, NUM_REQ*3: packed per-requester protection bits.
REQ-012 grant, output, NUM_REQ: one-hot owner of the current transfer.
REQ-013 done, output, NUM_REQ: one-hot, one-cycle completion pulse.
REQ-014 rsp_rdata, output, DATA_WIDTH: read data, valid while done is nonzero.
REQ-015 rsp_err, output, 1: error status, valid while done is nonzero.
REQ-016 rsp_timeout, output, 1: timeout status, valid while done is nonzero.
REQ-017 psel, penable, pwrite, output, 1 each: APB control.
REQ-018 paddr, output, ADDR_WIDTH; pwdata, output, DATA_WIDTH; pstrb, output, DATA_WIDTH/8; pprot, output, 3: APB request.
REQ-019 prdata, input, DATA_WIDTH; pready, input, 1; pslverr, input, 1: APB completer response.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-021 IDLE with any req_valid bit set: next cycle SETUP; winner latched into grant; winner's write/addr/wdata/pprot latched into APB outputs.
REQ-022 Arbitration SHALL be round-robin: search starts at index (last winner + 1) mod NUM_REQ; after reset the first search starts at index 0.
REQ-023 SETUP: psel=1, penable=0; next state always ACCESS.
REQ-024 ACCESS: psel=1, penable=1; stay while pready=0 and wait count < TIMEOUT.
REQ-025 ACCESS with pready=1: next cycle IDLE; done[winner]=1 for that one cycle; rsp_rdata=prdata (all zeros for writes); rsp_err=pslverr; rsp_timeout=0.
REQ-026 Wait counter: cleared on SETUP entry; increments once per ACCESS cycle with pready=0. If it reaches TIMEOUT: next IDLE, done[winner]=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 In the IDLE cycle carrying done, psel=0 and penable=0; a new grant may be decided in that same cycle, so back-to-back transfers are SETUP, ACCESS, IDLE, SETUP, and so on.
REQ-028 psel, pwrite, paddr, pwdata, pstrb, pprot and grant SHALL be held stable from SETUP through the final ACCESS cycle.
REQ-029 paddr SHALL be passed through unmodified, with no alignment; alignment faults are reported by the completer via pslverr.
REQ-030 pstrb SHALL be all ones for writes and all zeros for reads; pwdata SHALL be zero for reads.
REQ-031 A requester SHALL hold req_valid and its fields until its done pulse. A req_valid drop after grant is ignored and the transfer completes normally.
REQ-032 pready and pslverr SHALL be ignored outside ACCESS.
REQ-033 grant SHALL be zero in IDLE.

Reset
REQ-034 On a pclk edge with reset=1: state=IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, pprot, grant, done, rsp_rdata, rsp_err, rsp_timeout all 0; wait counter 0; round-robin pointer 0.
REQ-035 Reset asserted mid-transfer SHALL abort it with no done pulse; APB outputs are 0 on the following cycle.

Verification
REQ-036 Single read: req_valid=4'b0001, addr 0x4, pprot 3'b111; completer pready after 2 wait cycles with prdata 0xDEADBEEF -> psel high 4 cycles, done=4'b0001, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Round-robin: req_valid=4'b1111 held, zero-wait completer -> grant order 0,1,2,3,0 with each transfer 3 cycles apart.
REQ-038 Write with error: requester 2, write, addr 0x3, wdata 0x12345678; completer returns pslverr=1 -> pstrb=4'hF, pwdata=0x12345678 stable through ACCESS, done=4'b0100, rsp_err=1.
REQ-039 Timeout: pready held 0 -> after 16 wait cycles done pulses with rsp_err=1, rsp_timeout=1; next cycle psel=0.
REQ-040 Reset mid-ACCESS: reset=1 during wait cycle 3 -> no done pulse, all outputs 0 next cycle; the next request is granted to index 0 first.
REQ-041 Protocol check throughout: penable never high without psel, and APB outputs never change while psel=1 and pready=0.
